mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit memory/peripheral port among 4 requesters.
- Drives the 2-bit select of the existing 4:1 word multiplexer, which steers the winning requester's address/data onto the shared port.
- Holds each grant until the port acknowledges, the requester withdraws, or a watchdog timeout fires.
- Sits between the requesters (fetch, load/store unit, debug, DMA) and the shared port.

Parameters:
- TIMEOUT, 16, max cycles a grant is held without ack; legal range 2..255.
- CW, 8, width of the watchdog counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit i = requester i; level-sensitive.
- ack  input  1  one-cycle completion pulse from the shared port.
- grant  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  binary index of the current or most recent grantee; feeds the mux select.
- busy  output  1  high while any grant is active.
- timeout_err  output  1  one-cycle pulse when a grant is revoked by the watchdog.
- err_id  output  2  index of the revoked requester, valid with timeout_err and held until the next error.

Behaviour:
- Reset (async, takes effect immediately, also mid-grant):
  - grant=0, sel=2'b00, busy=0, timeout_err=0, err_id=0, counter=0.
  - Last-served pointer ptr=3, so requester 0 has first priority. State=IDLE.
- States are IDLE and GRANT.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next edge: grant=onehot(winner), sel=winner, busy=1, counter=0, state=GRANT.
  - Latency from req to grant is 1 cycle.
  - ack in IDLE is ignored.
- GRANT (grantee g):
  - Counter increments every cycle.
  - Exit conditions are evaluated with priority ack > withdraw > timeout:
    - ack=1: release; ptr=g.
    - req[g]=0 (withdraw, no ack): release; ptr=g; no error.
    - counter==TIMEOUT-1 with no ack and req[g] still high: release; ptr=g; timeout_err=1 for one cycle; err_id=g.
  - Release with another req pending (req & ~onehot(g) != 0, or req[g] re-asserted): arbitrate with the updated ptr. The next edge loads the new grant directly (back-to-back, no idle bubble) and clears the counter.
  - Release with nothing pending: next edge grant=0, busy=0, state=IDLE.
- Rotation: the just-served requester has lowest priority in the next arbitration. A continuously requesting grantee is served again only after all other pending requesters.
- sel:
  - Changes only on the edge where a new grant is loaded.
  - Holds its value while idle, so the mux output is stable between transactions.
- Invariants (to be asserted):
  - grant is always zero or one-hot.
  - busy == |grant.
  - When busy, grant[sel]=1.
- Counter never exceeds TIMEOUT-1; it saturates at that value and cannot wrap.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=4 and IDXW=2.
  - State encoding constants S_IDLE=1'b0, S_GRANT=1'b1.
- Sub-module rr_pick: combinational; inputs req[3:0] and ptr[1:0]; outputs any and idx[1:0]. Implements the rotate-and-priority-encode and is reused by other shared-resource arbiters.
- Top level holds the state register, ptr, counter, and output registers.

Test Plan:
- Reset then req=4'b0001 → grant=4'b0001 and sel=0 one cycle later; ack after 3 cycles → grant=0, busy=0 next cycle.
- req=4'b1111 held, ack pulsed every 2nd cycle of each grant → grant sequence 0001,0010,0100,1000,0001 with no idle cycles between grants.
- req=4'b0100 held, no ack, TIMEOUT=16 → grant released after 16 grant cycles, timeout_err pulses once, err_id=2.
- Ack and timeout in the same cycle (ack at cycle 16) → no timeout_err, normal release.
- Requester 1 drops req mid-grant while req[3]=1 → grant moves to 4'b1000 on the next edge, no error, sel=3.
- Reset asserted mid-grant (grant=4'b0010, sel=1) → grant=0, sel=0, busy=0 immediately without a clock edge; after release, req=4'b1010 → grant=4'b0010 (ptr back at 3).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the shared-port arbiters: requester count, index width
// and the two-state grant FSM encoding.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDXW  = 2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin pick: first set request scanning ptr+1, ptr+2, ... ptr (mod N_REQ).
// Purely combinational so any shared-resource arbiter can reuse it.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic             any,
  output logic [IDXW-1:0]  idx
);

  // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[IDXW'(int'(ptr) + k)]) begin
        any = 1'b1;
        idx = IDXW'(int'(ptr) + k);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for the shared 32-bit port: holds a grant until ack,
// withdraw or watchdog timeout, and drives the 4:1 mux select.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] grant,
  output logic [IDXW-1:0]  sel,
  output logic             busy,
  output logic             timeout_err,
  output logic [IDXW-1:0]  err_id,
  output arb_state_e       state_dbg
);

  // Handshake: req[i] is a level held until the requester sees grant[i] and its
  // transfer completes (ack) or it gives up (drops req[i]); ack is a one-cycle
  // pulse that only counts while a grant is active.

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0]  sel_q, sel_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [IDXW-1:0]  err_id_q, err_id_d;

  logic [IDXW-1:0]  pick_ptr;
  logic             pick_any;
  logic [IDXW-1:0]  pick_idx;
  logic             release_now;

  // While granted, sel_q is the grantee and becomes the new last-served pointer
  // on release, so the next pick can be computed in the same cycle.
  assign pick_ptr = (state_q == S_GRANT) ? sel_q : ptr_q;

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign release_now = ack || !req[sel_q] || (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    err_id_d = err_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_GRANT;
          grant_d = N_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          ptr_d = sel_q;
          if (!ack && req[sel_q]) begin
            err_d    = 1'b1;
            err_id_d = sel_q;
          end
          if (pick_any) begin
            grant_d = N_REQ'(1) << pick_idx;
            sel_d   = pick_idx;
            cnt_d   = '0;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
          end
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= IDXW'(N_REQ - 1);
      cnt_q    <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign busy        = |grant_q;
  assign timeout_err = err_q;
  assign err_id      = err_id_q;
  assign state_dbg   = state_q;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_busy_matches: assert property (@(posedge clk) disable iff (reset) busy == (|grant_q));
  a_sel_granted: assert property (@(posedge clk) disable iff (reset) busy |-> grant_q[sel_q]);
  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_LAST);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with hand-derived values, then
// random request/ack traffic checked against a cycle-level round-robin model.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;
  logic [1:0] err_id;
  arb_state_e state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: -1 means no grantee; held counts grant cycles so far.
  int m_g, m_ptr, m_sel, m_held, m_errid;
  bit m_err;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .grant       (grant),
    .sel         (sel),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_id      (err_id),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 3; m_sel = 0; m_held = 0; m_err = 0; m_errid = 0;
  endtask

  // Applies the arbitration rules for one rising edge with the current req/ack.
  task automatic model_edge();
    bit rel;
    int w;
    m_err = 0;
    if (m_g < 0) begin
      w = pick(req, m_ptr);
      if (w >= 0) begin m_g = w; m_sel = w; m_held = 1; end
    end else begin
      rel = 1'b1;
      if (ack) rel = 1'b1;
      else if (!req[m_g]) rel = 1'b1;
      else if (m_held == TIMEOUT) begin m_err = 1; m_errid = m_g; end
      else rel = 1'b0;
      if (rel) begin
        m_ptr = m_g;
        w = pick(req, m_ptr);
        if (w >= 0) begin m_g = w; m_sel = w; m_held = 1; end
        else m_g = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; ack = 1'b0;
    #2;
    n_checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: grant=%b sel=%0d busy=%b, want 0000/0/0", grant, sel, busy);
    end
    tick();
    tick();
    n_checks++;
    if (timeout_err !== 1'b0 || err_id !== 2'd0 || state_dbg !== S_IDLE) begin
      n_errors++;
      $display("FAIL reset_err: timeout_err=%b err_id=%0d state=%0d, want 0/0/0", timeout_err, err_id, state_dbg);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL single_grant: grant=%b sel=%0d busy=%b, want 0001/0/1", grant, sel, busy);
    end
    tick();
    tick();
    ack = 1'b1; req = 4'b0000;
    tick();
    ack = 1'b0;
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
      n_errors++;
      $display("FAIL single_release: grant=%b busy=%b sel=%0d, want 0000/0/0", grant, busy, sel);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      n_checks++;
      if (grant !== exp_g || sel !== 2'(i % 4) || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_grant%0d: grant=%b sel=%0d busy=%b, want %b/%0d/1", i, grant, sel, busy, exp_g, i % 4);
      end
      tick();
      n_checks++;
      if (grant !== exp_g || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL rr_hold%0d: grant=%b busy=%b, want %b/1", i, grant, busy, exp_g);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    req = 4'b0000;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0100;
    tick();
    for (int c = 2; c <= TIMEOUT; c++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0100 || timeout_err !== 1'b0) begin
        n_errors++;
        $display("FAIL to_hold_c%0d: grant=%b timeout_err=%b, want 0100/0", c, grant, timeout_err);
      end
    end
    tick();
    n_checks++;
    if (timeout_err !== 1'b1 || err_id !== 2'd2) begin
      n_errors++;
      $display("FAIL to_pulse: timeout_err=%b err_id=%0d, want 1/2", timeout_err, err_id);
    end
    n_checks++;
    if (grant !== 4'b0100 || sel !== 2'd2) begin
      n_errors++;
      $display("FAIL to_regrant: grant=%b sel=%0d, want 0100/2", grant, sel);
    end
    tick();
    n_checks++;
    if (timeout_err !== 1'b0 || err_id !== 2'd2) begin
      n_errors++;
      $display("FAIL to_single_pulse: timeout_err=%b err_id=%0d, want 0/2", timeout_err, err_id);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || err_id !== 2'd2) begin
      n_errors++;
      $display("FAIL to_idle: grant=%b busy=%b err_id=%0d, want 0000/0/2", grant, busy, err_id);
    end
  endtask

  task automatic test_ack_and_timeout();
    do_reset();
    req = 4'b0011;
    tick();
    for (int c = 2; c <= TIMEOUT; c++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (timeout_err !== 1'b0 || err_id !== 2'd0) begin
      n_errors++;
      $display("FAIL ack_vs_to_err: timeout_err=%b err_id=%0d, want 0/0", timeout_err, err_id);
    end
    n_checks++;
    if (grant !== 4'b0010 || sel !== 2'd1) begin
      n_errors++;
      $display("FAIL ack_vs_to_next: grant=%b sel=%0d, want 0010/1", grant, sel);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b1010;
    tick();
    n_checks++;
    if (grant !== 4'b0010 || sel !== 2'd1) begin
      n_errors++;
      $display("FAIL wd_first: grant=%b sel=%0d, want 0010/1", grant, sel);
    end
    tick();
    req = 4'b1000;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || sel !== 2'd3 || timeout_err !== 1'b0) begin
      n_errors++;
      $display("FAIL wd_move: grant=%b sel=%0d timeout_err=%b, want 1000/3/0", grant, sel, timeout_err);
    end
    req = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'd3) begin
      n_errors++;
      $display("FAIL wd_sel_hold: grant=%b busy=%b sel=%0d, want 0000/0/3", grant, busy, sel);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL async_mid_grant: grant=%b sel=%0d busy=%b, want 0000/0/0", grant, sel, busy);
    end
    req = 4'b1010;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (grant !== 4'b0010 || sel !== 2'd1) begin
      n_errors++;
      $display("FAIL async_ptr_restart: grant=%b sel=%0d, want 0010/1", grant, sel);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_grant;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      ack = (c < 300) ? ($urandom_range(0, 9) == 0) : 1'b0;
      tick();
      exp_grant = (m_g < 0) ? 4'b0000 : 4'(1 << m_g);
      n_checks++;
      if (grant !== exp_grant || sel !== 2'(m_sel) || busy !== (m_g >= 0)) begin
        n_errors++;
        $display("FAIL rand_grant c%0d: grant=%b sel=%0d busy=%b, want %b/%0d/%b",
                 c, grant, sel, busy, exp_grant, m_sel, m_g >= 0);
      end
      n_checks++;
      if (timeout_err !== m_err || err_id !== 2'(m_errid)) begin
        n_errors++;
        $display("FAIL rand_err c%0d: timeout_err=%b err_id=%0d, want %b/%0d",
                 c, timeout_err, err_id, m_err, m_errid);
      end
      n_checks++;
      if (state_dbg !== ((m_g >= 0) ? S_GRANT : S_IDLE)) begin
        n_errors++;
        $display("FAIL rand_state c%0d: state=%0d, want %0d", c, state_dbg, m_g >= 0);
      end
    end
    ack = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; req = '0; ack = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_ack_and_timeout();
    test_withdraw();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
